// File: rtl/sw_debounce_if.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// sw_debounce_if
// Groups the switch-debouncer signals.
//   din        : raw, asynchronous, possibly bouncing switch level
//   dout       : debounced, synchronous level
//   busy       : high while a candidate transition is being qualified
//   glitch_cnt : count of aborted qualifications, saturating at 255
//                (present only when SW_DEBOUNCE_GLITCH_CNT_EN is defined)
// The master modport drives din; the slave modport is the debouncer.
// -----------------------------------------------------------------------------
interface sw_debounce_if;
    logic       din;
    logic       dout;
    logic       busy;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output din, input  dout, input  busy, input  glitch_cnt);
    modport slave  (input  din, output dout, output busy, output glitch_cnt);
`else
    modport master (output din, input  dout, input  busy);
    modport slave  (input  din, output dout, output busy);
`endif
endinterface

// File: rtl/sw_debounce.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// sw_debounce
// Debounces a raw switch level. din is brought into the clk domain through a
// two-flop synchronizer; a four-state FSM only accepts a new level once it has
// been seen on STABLE_CYCLES consecutive synchronized samples. Any reversal
// while qualifying aborts and restarts counting from zero.
//
// Parameters
//   STABLE_CYCLES : consecutive samples required at the new level (1..2^CNT_W-1)
//   CNT_W         : stability counter width
// Ports
//   clk   : clock, all state changes on its rising edge
//   RESET : asynchronous active-low reset
//   bus   : sw_debounce_if.slave (din in; dout, busy[, glitch_cnt] out)
// Optional feature
//   SW_DEBOUNCE_GLITCH_CNT_EN : when defined, bus.glitch_cnt counts aborted
//                               qualifications, saturating at 255.
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic           clk,
    input  logic           RESET,
    sw_debounce_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_busy;

    logic             w_din_s;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_abort;
    logic             w_dout_nxt;
    logic             w_busy_nxt;

    // Two-flop synchronizer; the FSM only ever sees r_s2.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.din;
            r_s2 <= r_s1;
        end
    end

    assign w_din_s   = r_s2;
    assign w_cnt_inc = r_cnt + LP_ONE;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort     = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (w_din_s) begin
                    // A single-sample qualification skips the WAIT state.
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                        w_cnt_nxt   = LP_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (w_din_s) begin
                    if (w_cnt_inc == LP_TARGET) begin
                        w_state_nxt = IDLE_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_abort     = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!w_din_s) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = LP_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (!w_din_s) begin
                    if (w_cnt_inc == LP_TARGET) begin
                        w_state_nxt = IDLE_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_abort     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with r_state and have no combinational path from din.
    always_comb begin
        w_dout_nxt = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
        w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end

    assign bus.dout = r_dout;
    assign bus.busy = r_busy;

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Drives two debouncers (STABLE_CYCLES=4 and STABLE_CYCLES=1) with the same
// din and compares them against a history-based reference: the FSM sees din
// from two edges earlier, and dout flips once the last N such samples since
// the previous flip all differ from dout.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    logic clk   = 1'b0;
    logic RESET = 1'b0;

    always #1 clk = ~clk;

    sw_debounce_if bus4();
    sw_debounce_if bus1();

    sw_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus4)
    );

    sw_debounce #(.STABLE_CYCLES(1), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic din_hist[$];
    int   m_n[2] = '{4, 1};
    logic m_dout[2];
    logic m_busy[2];
    int   m_last_flip[2];
    int   m_glitch[2];

    function automatic logic sample_at(int j);
        return (j >= 2) ? din_hist[j-2] : 1'b0;
    endfunction

    function automatic logic [3:0] exp_vec();
        return {m_dout[0], m_busy[0], m_dout[1], m_busy[1]};
    endfunction

    function automatic logic [3:0] act_vec();
        return {bus4.dout, bus4.busy, bus1.dout, bus1.busy};
    endfunction

    task automatic model_reset();
        din_hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_dout[i]      = 1'b0;
            m_busy[i]      = 1'b0;
            m_last_flip[i] = -1;
            m_glitch[i]    = 0;
        end
    endtask

    task automatic model_edge(input logic d);
        int   e;
        int   first;
        logic s;
        logic all_diff;
        din_hist.push_back(d);
        e = din_hist.size() - 1;
        s = sample_at(e);
        for (int i = 0; i < 2; i++) begin
            first    = e - m_n[i] + 1;
            all_diff = 1'b0;
            if (first > m_last_flip[i]) begin
                all_diff = 1'b1;
                for (int j = first; j <= e; j++)
                    if (sample_at(j) == m_dout[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_dout[i]      = ~m_dout[i];
                m_last_flip[i] = e;
            end else if (m_busy[i] && (s == m_dout[i]) && (m_glitch[i] < 255)) begin
                m_glitch[i]++;
            end
            m_busy[i] = (s != m_dout[i]);
        end
    endtask

    // Drive din, take one rising edge, advance the model, settle away from edge.
    task automatic tick(input logic d);
        bus4.din = d;
        bus1.din = d;
        @(posedge clk);
        model_edge(d);
        #0.5;
    endtask

    // Assert reset between edges, check the immediate effect, release at negedge.
    task automatic do_reset(input logic d);
        bus4.din = d;
        bus1.din = d;
        RESET    = 1'b0;
        #0.25;
        n_checks++;
        if (act_vec() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b expected %b", act_vec(), 4'b0000);
        end
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (bus4.glitch_cnt !== 8'd0 || bus1.glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_glitch: got %0d/%0d expected 0/0", bus4.glitch_cnt, bus1.glitch_cnt);
        end
`endif
        model_reset();
        @(negedge clk);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        for (int t = 0; t < 20; t++) begin
            tick(1'b0);
            n_checks++;
            if (act_vec() !== 4'b0000 || exp_vec() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d: got %b model %b expected %b", t, act_vec(), exp_vec(), 4'b0000);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] want;
        for (int t = 0; t < 8; t++) begin
            tick(1'b1);
            want = {(t >= 5), (t >= 2 && t <= 4), (t >= 2), 1'b0};
            n_checks++;
            if (act_vec() !== want || exp_vec() !== want) begin
                n_fail++;
                $display("FAIL latency edge k+%0d: got %b model %b expected %b", t, act_vec(), exp_vec(), want);
            end
        end
        for (int t = 0; t < 8; t++) tick(1'b0);
        n_checks++;
        if (act_vec() !== 4'b0000) begin
            n_fail++;
            $display("FAIL latency_fall: got %b expected %b", act_vec(), 4'b0000);
        end
    endtask

    task automatic test_glitch();
        int g0;
        for (int t = 0; t < 10; t++) tick(1'b1);
        g0 = m_glitch[0];
        for (int t = 0; t < 10; t++) begin
            tick((t < 2) ? 1'b0 : 1'b1);
            n_checks++;
            if (bus4.dout !== 1'b1 || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch_hold t=%0d: got %b model %b (dout4 must stay 1)", t, act_vec(), exp_vec());
            end
        end
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (bus4.glitch_cnt !== 8'(g0 + 1) || bus1.glitch_cnt !== 8'(m_glitch[1])) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d/%0d expected %0d/%0d", bus4.glitch_cnt, bus1.glitch_cnt, g0 + 1, m_glitch[1]);
        end
`else
        n_checks++;
        if (m_glitch[0] !== g0 + 1) begin
            n_fail++;
            $display("FAIL glitch_model: got %0d expected %0d", m_glitch[0], g0 + 1);
        end
`endif
    endtask

    task automatic test_bounce();
        int   rises;
        int   rise_at;
        logic prev;
        for (int t = 0; t < 10; t++) tick(1'b0);
        rises   = 0;
        rise_at = -1;
        prev    = bus4.dout;
        for (int t = 0; t < 10; t++) begin
            tick((t % 2 == 0) ? 1'b1 : 1'b0);
            if (bus4.dout && !prev) rises++;
            prev = bus4.dout;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce t=%0d: got %b expected %b", t, act_vec(), exp_vec());
            end
        end
        for (int h = 0; h < 15; h++) begin
            tick(1'b1);
            if (bus4.dout && !prev) begin
                rises++;
                rise_at = h;
            end
            prev = bus4.dout;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_hold h=%0d: got %b expected %b", h, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (rises != 1 || rise_at != 5) begin
            n_fail++;
            $display("FAIL bounce_rise: got %0d rises at k+%0d expected 1 rise at k+5", rises, rise_at);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 10; t++) tick(1'b0);
        for (int t = 0; t < 4; t++) tick(1'b1);
        n_checks++;
        if (bus4.busy !== 1'b1 || bus4.dout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_qualify: got dout=%b busy=%b expected dout=0 busy=1", bus4.dout, bus4.busy);
        end
        do_reset(1'b1);
        for (int t = 0; t < 8; t++) begin
            tick(1'b1);
            n_checks++;
            if (bus4.dout !== (t >= 5) || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_requalify t=%0d: got %b model %b dout4 expected %b", t, act_vec(), exp_vec(), (t >= 5));
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   run;
        int   edges;
        do_reset(1'b0);
        edges = 0;
        while (edges < 400) begin
            lvl = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 7);
            for (int r = 0; r < run; r++) begin
                tick(lvl);
                edges++;
                n_checks++;
                if (act_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random edge=%0d: got %b expected %b", edges, act_vec(), exp_vec());
                end
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
                n_checks++;
                if (bus4.glitch_cnt !== 8'(m_glitch[0]) || bus1.glitch_cnt !== 8'(m_glitch[1])) begin
                    n_fail++;
                    $display("FAIL random_glitch edge=%0d: got %0d/%0d expected %0d/%0d", edges, bus4.glitch_cnt, bus1.glitch_cnt, m_glitch[0], m_glitch[1]);
                end
`endif
            end
        end
    endtask

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    task automatic test_glitch_sat();
        do_reset(1'b0);
        for (int p = 0; p < 300; p++) begin
            tick(1'b1);
            tick(1'b0);
        end
        n_checks++;
        if (bus4.glitch_cnt !== 8'd255 || m_glitch[0] != 255) begin
            n_fail++;
            $display("FAIL glitch_saturate: got %0d model %0d expected 255", bus4.glitch_cnt, m_glitch[0]);
        end
    endtask
`endif

    initial begin
        bus4.din = 1'b0;
        bus1.din = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_latency();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
        test_glitch_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive synchronized samples at the new level before dout changes; legal range 1..(2^CNT_W - 1).
REQ-002 Parameter CNT_W, default 8, stability counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset; RESET=0 forces reset state immediately, independent of clk.
REQ-005 din  input  1  raw, asynchronous, possibly bouncing level (switch/button).
REQ-006 dout  output  1  debounced, synchronous level; feeds the din input of the downstream edge-detector FSM.
REQ-007 busy  output  1  high while a candidate transition is being qualified (WAIT_HIGH or WAIT_LOW).

Function
REQ-008 din SHALL pass through a two-flop synchronizer (s1, s2); the FSM SHALL observe only s2 (din_s).
REQ-009 FSM states SHALL be IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; dout=0 in IDLE_LOW/WAIT_HIGH, dout=1 in IDLE_HIGH/WAIT_LOW; dout and busy SHALL be registered, with no combinational path from din.
REQ-010 IDLE_LOW: din_s=1 -> WAIT_HIGH with cnt=1; if STABLE_CYCLES=1, go directly to IDLE_HIGH instead; din_s=0 -> stay, cnt=0.
REQ-011 WAIT_HIGH: din_s=1 and cnt+1=STABLE_CYCLES -> IDLE_HIGH, cnt=0; din_s=1 otherwise -> cnt+1; din_s=0 -> IDLE_LOW, cnt=0 (glitch rejected).
REQ-012 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-010/REQ-011 with levels inverted, returning to IDLE_LOW after a qualified low.
REQ-013 Latency: with din held steady at the new level, dout SHALL change on the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new din level into s1.
REQ-014 Any din_s reversal inside a WAIT state SHALL abort the qualification and restart counting from zero; dout SHALL not toggle.
REQ-015 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-016 dout SHALL change at most once per STABLE_CYCLES clocks.

Reset
REQ-017 While RESET=0: s1=0, s2=0, state=IDLE_LOW, cnt=0, dout=0, busy=0, glitch_cnt=0 (when present).
REQ-018 Reset asserted mid-qualification SHALL discard the qualification; after release, the FSM SHALL restart from IDLE_LOW regardless of din.
REQ-019 The first rising edge after RESET rises SHALL be a normal operating edge.

Configuration
REQ-020 Macro SW_DEBOUNCE_GLITCH_CNT_EN defined: add output glitch_cnt [7:0], incremented on every aborted qualification (REQ-011 abort and its mirror), saturating at 255, reset to 0.
REQ-021 Macro SW_DEBOUNCE_GLITCH_CNT_EN undefined: port glitch_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (clk period 2 time units, STABLE_CYCLES=4)
REQ-022 Pulse RESET low, then release with din=0 -> dout=0, busy=0; stays so for 20 clocks.
REQ-023 Set din=1 before edge k and hold -> dout rises after edge k+5; busy is high after edges k+2..k+4 and low after edge k+5.
REQ-024 Settled high, din=0 for 2 clocks then back to 1 -> dout stays 1; glitch_cnt increments by 1 (macro defined).
REQ-025 Bounce din 0/1 every clock for 10 clocks, then hold 1 -> dout rises exactly once, 6 edges after the final rising edge of din.
REQ-026 Assert RESET low during WAIT_HIGH (cnt=2) -> dout=0, busy=0 immediately; after release with din=1, a full 6-edge qualification is required.
REQ-027 STABLE_CYCLES=1, din 0->1 -> dout rises on the 3rd edge; busy never asserts.
